shift_register_in: RTL and testbench
====================================

# shift_register_in

Serial-to-parallel receiver that consumes the one-bit-per-clock serial stream produced by the parallel-load output shift register and rebuilds data bytes. It detects a start bit, shifts in DATA_W data bits MSB first, and checks the stop bit. Each good byte is presented on a valid/ready holding register to the downstream consumer. Framing errors and overruns are flagged as one-cycle pulses.

## Interface
- DATA_W, 8, data bits per frame (frame length is DATA_W+2 bit-times)
- clk  input  1  single clock; one serial bit per rising edge
- reset  input  1  asynchronous, active-low; asserting low clears all state immediately
- SerialIn  input  1  serial line; idles high
- OutData  output  DATA_W  received byte in holding register
- Valid  output  1  OutData holds an unconsumed byte
- Ready  input  1  consumer accepts OutData on a clock where Valid=1
- FrameErr  output  1  one-cycle pulse: stop bit sampled low
- Overrun  output  1  one-cycle pulse: good byte dropped because holding register was full

## Operation
- Frame on SerialIn: start bit 0, then DATA_W data bits MSB first, then stop bit 1.
- The FSM has four states:
  - BREAK: entered on reset and after a framing error. Waits for SerialIn=1, then moves to IDLE. Treating the line as not-yet-idle prevents the low line during upstream reset being taken as a start bit.
  - IDLE: SerialIn=0 moves to DATA, clears the shift register and sets the bit counter to 0. SerialIn=1 stays in IDLE.
  - DATA: each clock shifts SerialIn into the LSB (shift left) and increments the counter. After DATA_W bits, moves to STOP.
  - STOP: if SerialIn=1, the byte is good and the FSM moves to IDLE. If SerialIn=0, FrameErr pulses, the byte is discarded and the FSM moves to BREAK.
- Delivering a good byte:
  - If Valid=0, or Valid=1 and Ready=1 on the same clock, OutData loads the byte and Valid is 1.
  - Otherwise OutData and Valid are unchanged, the byte is dropped and Overrun pulses.
- Handshake: when Valid=1 and Ready=1 with no new byte arriving, Valid clears on the next edge. Ready while Valid=0 has no effect. OutData is stable while Valid=1.
- Bit counter width is clog2(DATA_W+1). The counter never wraps mid-frame and is reset on each start bit.

## Timing
- Reset values: OutData=0, Valid=0, FrameErr=0, Overrun=0, state=BREAK, counter=0, shift register=0.
- Start bit sampled at edge t. Data bits are sampled at t+1..t+DATA_W and the stop bit at t+DATA_W+1.
- Valid (or FrameErr/Overrun) is registered and visible after edge t+DATA_W+1. For DATA_W=8: start at t, stop at t+9, outputs change at t+9.
- Back-to-back frames: a start bit may appear on the edge immediately after the stop bit (t+DATA_W+2). Sustained throughput is one byte per DATA_W+2 clocks.
- FrameErr and Overrun are high for exactly one cycle per event and never high together.
- Reset low mid-frame aborts the partial byte with no pulse. After reset releases, the FSM is in BREAK and needs one SerialIn=1 clock before a start bit is accepted.
- A new byte landing on the same edge that Ready consumes the old one: the new byte is loaded, Valid stays 1 and there is no Overrun.

## Structure
- Shared package holds:
  - the state enum (BREAK, IDLE, DATA, STOP);
  - the frame constants: START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1;
  - DATA_W default.
- One sub-module, serial_shift_in: a DATA_W-bit shift-left register with shift-enable and clear.
- The FSM, counter and holding register live in the top module.

## Test plan
- Basic frame: after reset, hold SerialIn=1 for 2 clocks, then send 0,1,0,1,0,0,1,0,1,1 (0xA5). Required: OutData=0xA5 and Valid=1 after the stop edge; with Ready=1 one cycle later, Valid drops next edge.
- Back-to-back: with Ready tied 1, send 0x3C then 0xC3 with no idle gap. Required: two Valid events exactly 10 clocks apart, with OutData 0x3C then 0xC3.
- Overrun: with Ready=0, send 0x11 then 0x22. Required: OutData stays 0x11, Valid stays 1, and Overrun pulses for 1 cycle at the second stop edge.
- Framing error: send a start bit and 0xFF with stop bit 0, keep the line low for 3 clocks, then high, then send 0x5A. Required: FrameErr pulses once and no Valid for 0xFF. 0x5A is received only after the line has been high for at least one clock.
- Reset mid-frame: assert reset low after 4 data bits of 0xF0. Required: all outputs 0 immediately. After release, a frame is not accepted until the line has been high for 1 clock, and a following 0x0F is received correctly.
- Simultaneous consume and load: with Valid=1 (0xAA), raise Ready exactly on the stop edge of 0x55. Required: OutData=0x55, Valid=1 and Overrun=0.

Source files
------------

// File: rtl/shift_register_in_pkg.sv
// Shared types and frame constants for the serial byte receiver.
package shift_register_in_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_BREAK = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_shift_in.sv
// Shift-left register: new serial bit enters at the LSB, so the first bit received ends up as the MSB.
module serial_shift_in #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_shift) begin
      r_data <= {r_data[DATA_W-2:0], i_bit};
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/shift_register_in.sv
// Serial-to-parallel receiver: start bit, DATA_W bits MSB first, stop bit,
// delivered through a valid/ready holding register with framing-error and overrun pulses.
module shift_register_in
  import shift_register_in_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SerialIn,
  output logic [DATA_W-1:0] OutData,
  output logic              Valid,
  input  logic              Ready,
  output logic              FrameErr,
  output logic              Overrun,
  output state_t            o_state
);

  // Handshake: a byte transfers on any rising edge where Valid=1 and Ready=1.
  // OutData never changes while Valid=1 unless that same edge consumes it.

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_out_data;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_overrun;

  logic              w_start;
  logic              w_shift;
  logic              w_good;
  logic              w_bad;
  logic [DATA_W-1:0] w_shreg;

  assign w_start = (r_state == ST_IDLE) && (SerialIn == START_BIT);
  assign w_shift = (r_state == ST_DATA);
  assign w_good  = (r_state == ST_STOP) && (SerialIn == STOP_BIT);
  assign w_bad   = (r_state == ST_STOP) && (SerialIn != STOP_BIT);

  serial_shift_in #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_start),
    .i_shift (w_shift),
    .i_bit   (SerialIn),
    .o_data  (w_shreg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BREAK;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        // A low line after reset or a bad stop is not trusted as a start bit.
        ST_BREAK: if (SerialIn == IDLE_LEVEL) r_state <= ST_IDLE;
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
          end
        end
        ST_DATA: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) r_state <= ST_STOP;
        end
        ST_STOP: r_state <= w_good ? ST_IDLE : ST_BREAK;
        default: r_state <= ST_BREAK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data  <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      r_overrun   <= 1'b0;
      if (w_good) begin
        if (!r_valid || Ready) begin
          r_out_data <= w_shreg;
          r_valid    <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign OutData  = r_out_data;
  assign Valid    = r_valid;
  assign FrameErr = r_frame_err;
  assign Overrun  = r_overrun;
  assign o_state  = r_state;

endmodule

// File: tb/tb_shift_register_in.sv
// Directed bench for the serial byte receiver with hand-computed expectations.
module tb_shift_register_in;
  import shift_register_in_pkg::*;

  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              SerialIn;
  logic [DATA_W-1:0] OutData;
  logic              Valid;
  logic              Ready;
  logic              FrameErr;
  logic              Overrun;
  state_t            o_state;

  int checks = 0;
  int errors = 0;

  shift_register_in #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .SerialIn (SerialIn),
    .OutData  (OutData),
    .Valid    (Valid),
    .Ready    (Ready),
    .FrameErr (FrameErr),
    .Overrun  (Overrun),
    .o_state  (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, take one clock edge, then settle past the edge.
  task automatic step(input logic b);
    SerialIn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    step(1'b0);
    for (int i = 7; i >= 0; i--) step(d[i]);
    step(stop_b);
  endtask

  initial begin
    reset    = 1'b0;
    Ready    = 1'b0;
    SerialIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  32'(OutData), 32'h0);
    chk("rst_valid", 32'(Valid), 32'h0);
    chk("rst_ferr",  32'(FrameErr), 32'h0);
    chk("rst_ovr",   32'(Overrun), 32'h0);
    chk("rst_state", 32'(o_state), 32'(ST_BREAK));
    reset = 1'b1;

    // Low line while in BREAK is ignored.
    step(1'b0);
    chk("break_hold", 32'(o_state), 32'(ST_BREAK));

    // Basic frame 0xA5.
    step(1'b1);
    chk("break_exit", 32'(o_state), 32'(ST_IDLE));
    step(1'b1);
    send_frame(8'hA5, 1'b1);
    chk("a5_valid", 32'(Valid), 32'h1);
    chk("a5_data",  32'(OutData), 32'hA5);
    chk("a5_ovr",   32'(Overrun), 32'h0);
    Ready = 1'b1;
    step(1'b1);
    chk("a5_drop", 32'(Valid), 32'h0);

    // Back-to-back with Ready held high.
    send_frame(8'h3C, 1'b1);
    chk("b2b1_valid", 32'(Valid), 32'h1);
    chk("b2b1_data",  32'(OutData), 32'h3C);
    step(1'b0);
    chk("b2b1_consumed", 32'(Valid), 32'h0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] v;
      v = 8'hC3;
      step(v[i]);
    end
    step(1'b1);
    chk("b2b2_valid", 32'(Valid), 32'h1);
    chk("b2b2_data",  32'(OutData), 32'hC3);
    step(1'b1);
    chk("b2b2_drop", 32'(Valid), 32'h0);
    Ready = 1'b0;

    // Overrun.
    send_frame(8'h11, 1'b1);
    chk("ovr1_data", 32'(OutData), 32'h11);
    chk("ovr1_pulse", 32'(Overrun), 32'h0);
    send_frame(8'h22, 1'b1);
    chk("ovr2_data",  32'(OutData), 32'h11);
    chk("ovr2_valid", 32'(Valid), 32'h1);
    chk("ovr2_pulse", 32'(Overrun), 32'h1);
    chk("ovr2_ferr",  32'(FrameErr), 32'h0);
    step(1'b1);
    chk("ovr_one_cycle", 32'(Overrun), 32'h0);
    chk("ovr_hold_data", 32'(OutData), 32'h11);
    Ready = 1'b1;
    step(1'b1);
    chk("ovr_drain", 32'(Valid), 32'h0);
    Ready = 1'b0;

    // Framing error: 0xFF with stop 0, then low for 3 clocks.
    send_frame(8'hFF, 1'b0);
    chk("fe_pulse", 32'(FrameErr), 32'h1);
    chk("fe_valid", 32'(Valid), 32'h0);
    chk("fe_ovr",   32'(Overrun), 32'h0);
    chk("fe_state", 32'(o_state), 32'(ST_BREAK));
    step(1'b0);
    chk("fe_one_cycle", 32'(FrameErr), 32'h0);
    step(1'b0);
    step(1'b0);
    chk("fe_stay_break", 32'(o_state), 32'(ST_BREAK));
    chk("fe_no_valid", 32'(Valid), 32'h0);
    step(1'b1);
    chk("fe_to_idle", 32'(o_state), 32'(ST_IDLE));
    send_frame(8'h5A, 1'b1);
    chk("5a_valid", 32'(Valid), 32'h1);
    chk("5a_data",  32'(OutData), 32'h5A);

    // Reset mid-frame while 0x5A still held.
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("mid_state", 32'(o_state), 32'(ST_DATA));
    reset = 1'b0;
    #1;
    chk("mid_rst_data",  32'(OutData), 32'h0);
    chk("mid_rst_valid", 32'(Valid), 32'h0);
    chk("mid_rst_ferr",  32'(FrameErr), 32'h0);
    chk("mid_rst_ovr",   32'(Overrun), 32'h0);
    chk("mid_rst_state", 32'(o_state), 32'(ST_BREAK));
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b0);
    chk("post_rst_break", 32'(o_state), 32'(ST_BREAK));
    step(1'b1);
    send_frame(8'h0F, 1'b1);
    chk("0f_valid", 32'(Valid), 32'h1);
    chk("0f_data",  32'(OutData), 32'h0F);
    Ready = 1'b1;
    step(1'b1);
    Ready = 1'b0;
    chk("0f_drop", 32'(Valid), 32'h0);

    // Simultaneous consume and load.
    send_frame(8'hAA, 1'b1);
    chk("aa_data", 32'(OutData), 32'hAA);
    step(1'b0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] v;
      v = 8'h55;
      step(v[i]);
    end
    chk("sim_hold", 32'(OutData), 32'hAA);
    Ready = 1'b1;
    step(1'b1);
    Ready = 1'b0;
    chk("sim_data",  32'(OutData), 32'h55);
    chk("sim_valid", 32'(Valid), 32'h1);
    chk("sim_ovr",   32'(Overrun), 32'h0);
    step(1'b1);
    chk("sim_keep", 32'(Valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
